// File: rtl/pia_pkg.sv
// Shared constants for the Apple-1 style keyboard/display PIA:
// register map, control-register bit positions and the strobe edge detector.
package pia_pkg;

  // Default 4-register window (KBD, KBDCR, DSP, DSPCR)
  localparam logic [15:0] PIA_BASE_DEFAULT = 16'hD010;

  // Register offsets within the window
  typedef enum logic [1:0] {
    REG_KBD   = 2'd0,
    REG_KBDCR = 2'd1,
    REG_DSP   = 2'd2,
    REG_DSPCR = 2'd3
  } pia_reg_e;

  // Control-register bit positions
  localparam int CR_VALID_BIT = 7;
  localparam int CR_OVF_BIT   = 6;

  // Host strobe shift register length: two synchroniser flops plus one
  // history flop, so a rising edge becomes a 1-cycle pulse two cycles later.
  localparam int EDGE_SR_LEN = 3;

  // Rising-edge pulse from the two oldest shift-register taps
  function automatic logic edge_pulse(input logic newer, input logic older);
    return newer & ~older;
  endfunction

endpackage

// File: rtl/pia_fifo_io_sync_fifo.sv
// Small single-clock FIFO with a combinational head view.
// Simultaneous push+pop is always honoured when the FIFO is non-empty,
// so a full FIFO still accepts a push in the same cycle as a pop.
module sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [DW-1:0]              push_data,
  input  logic                       pop,
  output logic [DW-1:0]              head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic pop_ok;
  logic push_ok;

  // Accept/drop decisions and next pointer/count values
  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == CW'(DEPTH));
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
    drop    = push & ~push_ok;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Never expose stale or uninitialised storage when empty
    head  = empty ? '0 : mem[rd_ptr_q];
    count = count_q;
  end

  // Pointer and occupancy state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents need no reset because head is gated by empty
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/pia_fifo_io.sv
// Apple-1 style PIA with keyboard and display FIFOs between the 6502 bus
// and the host transactor. Address decode and read data are registered so
// they line up with the synchronous memory read in the wrapper's DI mux.
module pia_fifo_io
  import pia_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = PIA_BASE_DEFAULT,
  parameter int          KBD_DEPTH = 4,
  parameter int          DSP_DEPTH = 4
) (
  input  logic                          clk_dut,
  input  logic                          reset_n,
  input  logic [15:0]                   ab,
  input  logic                          we,
  input  logic [7:0]                    do_cpu,
  input  logic                          rdy,
  output logic                          pia_sel,
  output logic [7:0]                    pia_di,
  input  logic                          kbd_wr,
  input  logic [7:0]                    kbd_in,
  output logic [$clog2(KBD_DEPTH):0]    kbd_count,
  input  logic                          dsp_rd,
  output logic [7:0]                    dsp_out,
  output logic [$clog2(DSP_DEPTH):0]    dsp_count
);

  // Host strobe edge detectors
  logic [EDGE_SR_LEN-1:0] kbd_sr_q, kbd_sr_d;
  logic [EDGE_SR_LEN-1:0] dsp_sr_q, dsp_sr_d;
  logic                   kbd_pulse;
  logic                   dsp_pulse;

  // Registered bus-side state
  logic       pia_sel_q, pia_sel_d;
  logic [7:0] pia_di_q,  pia_di_d;
  logic       kbd_ovf_q, kbd_ovf_d;
  logic       dsp_ovf_q, dsp_ovf_d;
  logic [6:0] last_wr_q, last_wr_d;

  // Decode
  logic [15:0] offs;
  logic        hit;
  pia_reg_e    reg_sel;
  logic        cpu_rd;
  logic        cpu_wr;
  logic [7:0]  rd_data;

  // FIFO handshakes
  logic       kbd_push, kbd_pop, kbd_drop, kbd_empty;
  logic [7:0] kbd_push_data, kbd_head;
  logic       dsp_push, dsp_pop, dsp_drop, dsp_full;

  // Only the low seven key bits are stored; bit 7 is forced to the valid flag
  logic unused_kbd_msb;
  logic unused_kbd_full;
  logic unused_dsp_empty;
  assign unused_kbd_msb = kbd_in[7];

  // Window decode, FIFO requests, flag updates and read-data mux
  always_comb begin
    offs    = ab - BASE_ADDR;
    hit     = (offs[15:2] == 14'd0);
    reg_sel = pia_reg_e'(offs[1:0]);
    cpu_rd  = hit & ~we & rdy;
    cpu_wr  = hit &  we & rdy;

    kbd_sr_d  = {kbd_sr_q[EDGE_SR_LEN-2:0], kbd_wr};
    dsp_sr_d  = {dsp_sr_q[EDGE_SR_LEN-2:0], dsp_rd};
    kbd_pulse = edge_pulse(kbd_sr_q[EDGE_SR_LEN-2], kbd_sr_q[EDGE_SR_LEN-1]);
    dsp_pulse = edge_pulse(dsp_sr_q[EDGE_SR_LEN-2], dsp_sr_q[EDGE_SR_LEN-1]);

    kbd_push      = kbd_pulse;
    kbd_push_data = {1'b1, kbd_in[6:0]};
    kbd_pop       = cpu_rd & (reg_sel == REG_KBD);
    dsp_push      = cpu_wr & (reg_sel == REG_DSP);
    dsp_pop       = dsp_pulse;

    // Overflow flags: a drop in the same cycle as a status read keeps the flag set
    kbd_ovf_d = kbd_ovf_q;
    if (cpu_rd && reg_sel == REG_KBDCR) kbd_ovf_d = 1'b0;
    if (kbd_drop)                       kbd_ovf_d = 1'b1;

    dsp_ovf_d = dsp_ovf_q;
    if (cpu_rd && reg_sel == REG_DSPCR) dsp_ovf_d = 1'b0;
    if (dsp_drop)                       dsp_ovf_d = 1'b1;

    last_wr_d = last_wr_q;
    if (dsp_push && !dsp_drop) last_wr_d = do_cpu[6:0];

    rd_data = 8'h00;
    case (reg_sel)
      REG_KBD: rd_data = kbd_head;
      REG_KBDCR: begin
        rd_data[CR_VALID_BIT] = ~kbd_empty;
        rd_data[CR_OVF_BIT]   = kbd_ovf_q;
      end
      REG_DSP: rd_data = {dsp_full, last_wr_q};
      REG_DSPCR: rd_data[CR_OVF_BIT] = dsp_ovf_q;
      default: rd_data = 8'h00;
    endcase

    // Read data follows the bus even while rdy is low; only side effects are gated
    pia_sel_d = hit;
    pia_di_d  = (hit && !we) ? rd_data : pia_di_q;
  end

  // Bus-side and strobe state
  always_ff @(posedge clk_dut or negedge reset_n) begin
    if (!reset_n) begin
      kbd_sr_q  <= '0;
      dsp_sr_q  <= '0;
      pia_sel_q <= 1'b0;
      pia_di_q  <= 8'h00;
      kbd_ovf_q <= 1'b0;
      dsp_ovf_q <= 1'b0;
      last_wr_q <= 7'h00;
    end else begin
      kbd_sr_q  <= kbd_sr_d;
      dsp_sr_q  <= dsp_sr_d;
      pia_sel_q <= pia_sel_d;
      pia_di_q  <= pia_di_d;
      kbd_ovf_q <= kbd_ovf_d;
      dsp_ovf_q <= dsp_ovf_d;
      last_wr_q <= last_wr_d;
    end
  end

  assign pia_sel = pia_sel_q;
  assign pia_di  = pia_di_q;

  sync_fifo #(
    .DW    (8),
    .DEPTH (KBD_DEPTH)
  ) u_kbd_fifo (
    .clk       (clk_dut),
    .rst_n     (reset_n),
    .push      (kbd_push),
    .push_data (kbd_push_data),
    .pop       (kbd_pop),
    .head      (kbd_head),
    .full      (unused_kbd_full),
    .empty     (kbd_empty),
    .count     (kbd_count),
    .drop      (kbd_drop)
  );

  sync_fifo #(
    .DW    (8),
    .DEPTH (DSP_DEPTH)
  ) u_dsp_fifo (
    .clk       (clk_dut),
    .rst_n     (reset_n),
    .push      (dsp_push),
    .push_data (do_cpu),
    .pop       (dsp_pop),
    .head      (dsp_out),
    .full      (dsp_full),
    .empty     (unused_dsp_empty),
    .count     (dsp_count),
    .drop      (dsp_drop)
  );

endmodule

// File: tb/tb_pia_fifo_io.sv
// Directed bench for pia_fifo_io: keyboard and display FIFO paths, status
// registers, overflow handling, rdy gating and asynchronous reset.
`timescale 1ns/1ps
module tb_pia_fifo_io;

  logic        clk_dut = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] ab      = 16'h0000;
  logic        we      = 1'b0;
  logic [7:0]  do_cpu  = 8'h00;
  logic        rdy     = 1'b1;
  logic        pia_sel;
  logic [7:0]  pia_di;
  logic        kbd_wr  = 1'b0;
  logic [7:0]  kbd_in  = 8'h00;
  logic [2:0]  kbd_count;
  logic        dsp_rd  = 1'b0;
  logic [7:0]  dsp_out;
  logic [2:0]  dsp_count;

  int n_checks = 0;
  int n_fail   = 0;

  pia_fifo_io #(
    .BASE_ADDR (16'hD010),
    .KBD_DEPTH (4),
    .DSP_DEPTH (4)
  ) dut (
    .clk_dut   (clk_dut),
    .reset_n   (reset_n),
    .ab        (ab),
    .we        (we),
    .do_cpu    (do_cpu),
    .rdy       (rdy),
    .pia_sel   (pia_sel),
    .pia_di    (pia_di),
    .kbd_wr    (kbd_wr),
    .kbd_in    (kbd_in),
    .kbd_count (kbd_count),
    .dsp_rd    (dsp_rd),
    .dsp_out   (dsp_out),
    .dsp_count (dsp_count)
  );

  always #5 clk_dut = ~clk_dut;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample just after the edge
  task automatic tick();
    @(posedge clk_dut);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic cpu_read(input logic [15:0] addr, input logic r);
    ab  = addr;
    we  = 1'b0;
    rdy = r;
    tick();
    ab  = 16'h0000;
    rdy = 1'b1;
    $display("cpu read  %h rdy=%0b -> pia_di=%h kbd_count=%0d", addr, r, pia_di, kbd_count);
  endtask

  task automatic cpu_write(input logic [15:0] addr, input logic [7:0] d);
    ab     = addr;
    we     = 1'b1;
    do_cpu = d;
    rdy    = 1'b1;
    tick();
    ab = 16'h0000;
    we = 1'b0;
    $display("cpu write %h <- %h dsp_count=%0d", addr, d, dsp_count);
  endtask

  // One full host key strobe: rise, hold past the detector, fall and settle
  task automatic push_key(input logic [7:0] k);
    kbd_in = k;
    kbd_wr = 1'b1;
    ticks(3);
    kbd_wr = 1'b0;
    ticks(3);
    $display("host key  %h kbd_count=%0d", k, kbd_count);
  endtask

  // One full host display pop, checking the head before popping
  task automatic host_pop(input string tag, input logic [7:0] exp);
    chk(tag, dsp_out, exp);
    dsp_rd = 1'b1;
    ticks(3);
    dsp_rd = 1'b0;
    ticks(3);
    $display("host pop  %h dsp_count=%0d", exp, dsp_count);
  endtask

  initial begin
    // ---- reset state (asynchronous, before any clock)
    #1;
    chk("rst_sel",   {7'd0, pia_sel}, 8'h00);
    chk("rst_di",    pia_di,          8'h00);
    chk("rst_kcnt",  {5'd0, kbd_count}, 8'h00);
    chk("rst_dcnt",  {5'd0, dsp_count}, 8'h00);
    chk("rst_dout",  dsp_out,         8'h00);
    ticks(2);
    reset_n = 1'b1;
    tick();

    // ---- 1: single key
    kbd_in = 8'h41;
    kbd_wr = 1'b1;
    ticks(3);
    chk("t1_kcnt_after3", {5'd0, kbd_count}, 8'h01);
    kbd_wr = 1'b0;
    ticks(3);
    chk("t1_kcnt_single", {5'd0, kbd_count}, 8'h01);
    cpu_read(16'hD011, 1'b1);
    chk("t1_kbdcr", pia_di, 8'h80);
    chk("t1_sel",   {7'd0, pia_sel}, 8'h01);
    cpu_read(16'hD010, 1'b1);
    chk("t1_kbd",   pia_di, 8'hC1);
    chk("t1_kcnt0", {5'd0, kbd_count}, 8'h00);
    tick();
    chk("t1_sel_idle", {7'd0, pia_sel}, 8'h00);

    // ---- 2: keyboard overflow
    push_key(8'h31);
    push_key(8'h32);
    push_key(8'h33);
    push_key(8'h34);
    push_key(8'h35);
    chk("t2_kcnt4", {5'd0, kbd_count}, 8'h04);
    cpu_read(16'hD011, 1'b1);
    chk("t2_kbdcr_ovf", pia_di, 8'hC0);
    cpu_read(16'hD011, 1'b1);
    chk("t2_kbdcr_clr", pia_di, 8'h80);
    cpu_read(16'hD010, 1'b1);
    chk("t2_key1", pia_di, 8'hB1);
    cpu_read(16'hD010, 1'b1);
    chk("t2_key2", pia_di, 8'hB2);
    cpu_read(16'hD010, 1'b1);
    chk("t2_key3", pia_di, 8'hB3);
    cpu_read(16'hD010, 1'b1);
    chk("t2_key4", pia_di, 8'hB4);
    chk("t2_kcnt0", {5'd0, kbd_count}, 8'h00);
    cpu_read(16'hD010, 1'b1);
    chk("t2_kbd_empty", pia_di, 8'h00);

    // ---- 3: display fill, overflow, drain
    cpu_write(16'hD012, 8'h8D);
    cpu_write(16'hD012, 8'hC1);
    cpu_write(16'hD012, 8'hC2);
    cpu_write(16'hD012, 8'hC3);
    chk("t3_dcnt4", {5'd0, dsp_count}, 8'h04);
    cpu_read(16'hD012, 1'b1);
    chk("t3_dsp_busy", pia_di, 8'hC3);
    cpu_read(16'hD013, 1'b1);
    chk("t3_dspcr_noovf", pia_di, 8'h00);
    cpu_write(16'hD012, 8'h55);
    chk("t3_dcnt_sat", {5'd0, dsp_count}, 8'h04);
    cpu_read(16'hD013, 1'b1);
    chk("t3_dspcr_ovf", pia_di, 8'h40);
    cpu_read(16'hD013, 1'b1);
    chk("t3_dspcr_clr", pia_di, 8'h00);
    host_pop("t3_pop1", 8'h8D);
    host_pop("t3_pop2", 8'hC1);
    host_pop("t3_pop3", 8'hC2);
    host_pop("t3_pop4", 8'hC3);
    chk("t3_dcnt0", {5'd0, dsp_count}, 8'h00);
    chk("t3_dout_empty", dsp_out, 8'h00);

    // ---- 4: full display, same-cycle host pop and CPU push
    cpu_write(16'hD012, 8'h01);
    cpu_write(16'hD012, 8'h02);
    cpu_write(16'hD012, 8'h03);
    cpu_write(16'hD012, 8'h04);
    dsp_rd = 1'b1;
    ticks(2);
    cpu_write(16'hD012, 8'h05);
    chk("t4_dcnt4", {5'd0, dsp_count}, 8'h04);
    chk("t4_head", dsp_out, 8'h02);
    dsp_rd = 1'b0;
    ticks(3);
    cpu_read(16'hD013, 1'b1);
    chk("t4_dspcr", pia_di, 8'h00);
    host_pop("t4_pop1", 8'h02);
    host_pop("t4_pop2", 8'h03);
    host_pop("t4_pop3", 8'h04);
    host_pop("t4_pop4", 8'h05);
    chk("t4_dcnt0", {5'd0, dsp_count}, 8'h00);

    // ---- 5: rdy gating
    push_key(8'h61);
    cpu_read(16'hD010, 1'b0);
    chk("t5_di_rdy0",   pia_di, 8'hE1);
    chk("t5_kcnt_rdy0", {5'd0, kbd_count}, 8'h01);
    cpu_read(16'hD010, 1'b1);
    chk("t5_di_rdy1",   pia_di, 8'hE1);
    chk("t5_kcnt_rdy1", {5'd0, kbd_count}, 8'h00);

    // ---- 6: asynchronous reset mid-burst
    push_key(8'h11);
    push_key(8'h12);
    push_key(8'h13);
    chk("t6_kcnt3", {5'd0, kbd_count}, 8'h03);
    cpu_write(16'hD012, 8'hA1);
    cpu_write(16'hD012, 8'hA2);
    cpu_write(16'hD012, 8'hA3);
    cpu_write(16'hD012, 8'hA4);
    cpu_write(16'hD012, 8'hA5);
    cpu_read(16'hD011, 1'b1);
    chk("t6_kbdcr_pre", pia_di, 8'h80);
    @(negedge clk_dut);
    reset_n = 1'b0;
    #1;
    chk("t6_kcnt", {5'd0, kbd_count}, 8'h00);
    chk("t6_dcnt", {5'd0, dsp_count}, 8'h00);
    chk("t6_di",   pia_di,            8'h00);
    chk("t6_sel",  {7'd0, pia_sel},   8'h00);
    chk("t6_dout", dsp_out,           8'h00);
    @(posedge clk_dut);
    #1;
    reset_n = 1'b1;
    tick();
    cpu_read(16'hD013, 1'b1);
    chk("t6_dspcr", pia_di, 8'h00);
    cpu_read(16'hD011, 1'b1);
    chk("t6_kbdcr", pia_di, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
